// File: rtl/i2s_dac_tx_pkg.sv
// Shared constants for the I2S DAC transmit path: FSM encoding, default sizes
// and the daclrc level that marks the left channel.
package i2s_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic LRC_LEFT = 1'b0;

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        WAIT_MSB = 4'b0010,
        SHIFT    = 4'b0100,
        PAD      = 4'b1000
    } state_e;

endpackage

// File: rtl/i2s_dac_tx_async_edge_sync.sv
// Multi-flop synchronizer for a codec-driven pin followed by one edge-detect
// register; emits single-clk rise/fall pulses and the synchronized level.
module async_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the synchronizer, then remember the last settled level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S playback transmitter: buffers one stereo pair and shifts it MSB-first
// onto dacdat, timed by the codec-mastered bclk/daclrc.
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bclk,
    input  logic                  daclrc,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic [DATA_WIDTH-1:0] sample_left,
    input  logic [DATA_WIDTH-1:0] sample_right,
    output logic                  dacdat,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int              CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(DATA_WIDTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic bclk_fall_s;
    logic bclk_rise_unused_s;
    logic bclk_level_unused_s;
    logic lrc_level_s;
    logic lrc_rise_s;
    logic lrc_fall_s;
    logic left_start_s;
    logic right_start_s;
    logic accept_s;
    logic full_d;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] hold_l_q;
    logic [DATA_WIDTH-1:0] hold_r_q;
    logic [DATA_WIDTH-1:0] pend_r_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CW-1:0]         cnt_q;
    logic                  full_q;
    logic                  ready_q;
    logic                  dacdat_q;
    logic                  frame_start_q;
    logic                  underrun_q;

    async_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (bclk),
        .level_o (bclk_level_unused_s),
        .rise_o  (bclk_rise_unused_s),
        .fall_o  (bclk_fall_s)
    );

    async_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrc_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (daclrc),
        .level_o (lrc_level_s),
        .rise_o  (lrc_rise_s),
        .fall_o  (lrc_fall_s)
    );

    // The new level after an edge tells which channel is starting.
    assign left_start_s  = (lrc_rise_s | lrc_fall_s) & (lrc_level_s == LRC_LEFT);
    assign right_start_s = (lrc_rise_s | lrc_fall_s) & (lrc_level_s != LRC_LEFT);
    assign accept_s      = sample_valid & ready_q;

    // Holding-buffer occupancy; an accept can only happen while empty, so it never races a consume.
    always_comb begin
        full_d = full_q;
        if (accept_s) begin
            full_d = 1'b1;
        end else if (left_start_s) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Channel sequencing, serializer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            pend_r_q      <= '0;
            shreg_q       <= '0;
            cnt_q         <= '0;
            full_q        <= 1'b0;
            ready_q       <= 1'b1;
            dacdat_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            full_q        <= full_d;
            ready_q       <= ~full_d;
            if (accept_s) begin
                hold_l_q <= sample_left;
                hold_r_q <= sample_right;
            end
            // Word-clock edges win over a coincident bclk fall, so that bit is never shifted.
            if (left_start_s) begin
                frame_start_q <= 1'b1;
                state_q       <= WAIT_MSB;
                cnt_q         <= '0;
                if (full_q) begin
                    shreg_q  <= hold_l_q;
                    pend_r_q <= hold_r_q;
                end else begin
                    shreg_q    <= '0;
                    pend_r_q   <= '0;
                    underrun_q <= 1'b1;
                end
            end else if (right_start_s && (state_q != IDLE)) begin
                shreg_q <= pend_r_q;
                cnt_q   <= '0;
                state_q <= WAIT_MSB;
            end else if (bclk_fall_s) begin
                case (state_q)
                    WAIT_MSB: begin
                        dacdat_q <= shreg_q[DATA_WIDTH-1];
                        shreg_q  <= shreg_q << 1;
                        cnt_q    <= CNT_ONE;
                        state_q  <= SHIFT;
                    end
                    SHIFT: begin
                        if (cnt_q >= CNT_MAX) begin
                            dacdat_q <= 1'b0;
                            state_q  <= PAD;
                        end else begin
                            dacdat_q <= shreg_q[DATA_WIDTH-1];
                            shreg_q  <= shreg_q << 1;
                            cnt_q    <= cnt_q + 1'b1;
                        end
                    end
                    PAD: begin
                        dacdat_q <= 1'b0;
                    end
                    IDLE: begin
                        dacdat_q <= 1'b0;
                    end
                    default: begin
                        dacdat_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sample_ready = ready_q;
    assign dacdat       = dacdat_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Randomized scoreboard bench for i2s_dac_tx: a frame-level model predicts
// every bit seen at bclk rise and the underrun flag of each frame start.
module tb_i2s_dac_tx;

    localparam int DW       = 16;
    localparam int CLK_HALF = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bclk = 1'b0;
    logic          daclrc = 1'b1;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic [DW-1:0] sample_left = '0;
    logic [DW-1:0] sample_right = '0;
    logic          dacdat;
    logic          frame_start;
    logic          underrun;

    i2s_dac_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .bclk         (bclk),
        .daclrc       (daclrc),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .dacdat       (dacdat),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #(CLK_HALF) clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit exp_q[$];
    bit ur_q[$];

    // frame-level reference model
    bit            idle_m = 1'b1;
    bit            buf_full_m = 1'b0;
    bit            last_m = 1'b0;
    logic [DW-1:0] hold_l_m = '0;
    logic [DW-1:0] hold_r_m = '0;
    logic [DW-1:0] pend_m = '0;
    logic [DW-1:0] word_m = '0;

    // per-half controls
    int            offer_cyc = -1;
    int            rst_cyc = -1;
    int            rel_cyc = -1;
    logic [DW-1:0] offer_l = '0;
    logic [DW-1:0] offer_r = '0;
    longint        t_fall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // One bclk period: fall (with optional word-clock edge), 8 clk low, rise, 8 clk high.
    task automatic bclk_cycle(input bit lvl, input int i);
        bit e;
        @(negedge clk);
        bclk = 1'b0;
        if (i == 0) daclrc = lvl;
        t_fall = $time;
        if (i == 0) begin
            if (lvl == 1'b0) begin
                idle_m = 1'b0;
                ur_q.push_back(!buf_full_m);
                word_m = buf_full_m ? hold_l_m : '0;
                pend_m = buf_full_m ? hold_r_m : '0;
                buf_full_m = 1'b0;
            end else if (!idle_m) begin
                word_m = pend_m;
            end
        end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (k == 2 && i == offer_cyc) begin
                check("ready_at_offer", sample_ready, 1);
                sample_valid = 1'b1;
                sample_left  = offer_l;
                sample_right = offer_r;
            end
            if (k == 3 && i == offer_cyc) begin
                sample_valid = 1'b0;
                buf_full_m = 1'b1;
                hold_l_m = offer_l;
                hold_r_m = offer_r;
            end
            if (k == 4 && i == rst_cyc) begin
                reset = 1'b1;
                #1;
                check("dacdat_on_reset", dacdat, 0);
                idle_m = 1'b1;
                buf_full_m = 1'b0;
                pend_m = '0;
                last_m = 1'b0;
            end
            if (k == 4 && i == rel_cyc) reset = 1'b0;
            if (k == 5) check("sample_ready", sample_ready, !buf_full_m);
        end
        @(negedge clk);
        if (idle_m)       e = 1'b0;
        else if (i == 0)  e = last_m;
        else if (i <= DW) e = word_m[DW-i];
        else              e = 1'b0;
        last_m = e;
        exp_q.push_back(e);
        bclk = 1'b1;
        repeat (7) @(negedge clk);
    endtask

    task automatic half(input bit lvl, input int n);
        for (int i = 0; i < n; i++) bclk_cycle(lvl, i);
        offer_cyc = -1;
        rst_cyc = -1;
        rel_cyc = -1;
    endtask

    task automatic set_offer(input int cyc, input logic [DW-1:0] l, input logic [DW-1:0] r);
        offer_cyc = cyc;
        offer_l = l;
        offer_r = r;
    endtask

    // Serial-data scoreboard: one expected bit per bclk rise at the pin.
    always @(posedge bclk) begin
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dacdat_bit: got %0b with no expected bit queued", dacdat);
        end else begin
            check("dacdat_bit", dacdat, exp_q.pop_front());
        end
    end

    // Frame-start scoreboard: each pulse pops the predicted underrun flag.
    always @(negedge clk) begin
        if (frame_start) begin
            if (ur_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_start: got unexpected pulse, required none");
            end else begin
                check("underrun", underrun, ur_q.pop_front());
            end
        end else if (underrun) begin
            checks++;
            failures++;
            $display("FAIL underrun_alone: got 1 without frame_start, required 0");
        end
    end

    // Pin-to-dacdat latency: every change lands 3 clk after the bclk fall.
    logic prev_dacdat = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_dacdat = dacdat;
        end else if (dacdat !== prev_dacdat) begin
            check("latency", 32'($time - t_fall), 32'(6 * CLK_HALF));
            prev_dacdat = dacdat;
        end
    end

    initial begin
        int nl;
        int nr;
        repeat (3) @(negedge clk);
        check("rst_dacdat", dacdat, 0);
        check("rst_ready", sample_ready, 1);
        check("rst_frame_start", frame_start, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b0;

        // pair offered while idle, then transmitted in the first frame
        set_offer(1, 16'hA5C3, 16'h0F01);
        half(1'b1, 3);
        half(1'b0, 32);
        half(1'b1, 32);

        // nothing supplied: underrun frame of zeros
        half(1'b0, 32);
        half(1'b1, 32);

        // accept on the lrc_fall clk with empty buffer, then next frame carries it
        set_offer(0, 16'h8000, 16'h7FFF);
        half(1'b0, 32);
        half(1'b1, 32);
        half(1'b0, 32);
        set_offer(3, 16'hFFFF, 16'($urandom));
        half(1'b1, 32);

        // short half-frames truncate
        half(1'b0, 12);
        set_offer(4, 16'($urandom), 16'($urandom));
        half(1'b1, 12);

        // reset mid-left, release while daclrc high, resume on next lrc_fall
        rst_cyc = 8;
        half(1'b0, 32);
        rel_cyc = 5;
        set_offer(10, 16'($urandom), 16'($urandom));
        half(1'b1, 32);
        half(1'b0, 32);
        half(1'b1, 32);

        // randomized frames: lengths around DW, random offers
        repeat (12) begin
            nl = $urandom_range(10, 34);
            nr = $urandom_range(10, 34);
            if ($urandom_range(0, 3) != 0)
                set_offer($urandom_range(1, nl - 1), 16'($urandom), 16'($urandom));
            half(1'b0, nl);
            if (!buf_full_m && ($urandom_range(0, 1) == 1))
                set_offer($urandom_range(1, nr - 1), 16'($urandom), 16'($urandom));
            half(1'b1, nr);
        end

        half(1'b0, 2);
        repeat (10) @(negedge clk);
        check("exp_bits_drained", exp_q.size(), 0);
        check("frame_starts_seen", ur_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
